// File: rtl/mem_dma_master_pkg.sv
// Shared types, widths and bus constants for the memory-to-memory DMA master.
package mem_dma_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [STRB_W-1:0] WSTRB_READ = 4'h0;
  localparam logic [STRB_W-1:0] WSTRB_WORD = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RGAP,
    ST_WR,
    ST_WGAP,
    ST_DONE,
    ST_ERR
  } state_t;

  // One bus request as presented on mem_addr/mem_wdata/mem_wstrb
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

  function automatic logic is_active(input state_t s);
    return s inside {ST_RD, ST_RGAP, ST_WR, ST_WGAP};
  endfunction

endpackage

// File: rtl/mem_dma_master_bus_port.sv
// Holds one native-bus request stable until it completes or stalls for TIMEOUT cycles.
module mem_dma_master_bus_port
  import mem_dma_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  bus_req_t          req,
  input  logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              xfer_ok_c,
  output logic              xfer_timeout_c
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;

  // A ready arriving on the last allowed wait cycle still wins over the abort
  assign xfer_ok_c      = valid & ready;
  assign xfer_timeout_c = valid & ~ready & (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      wstrb    <= '0;
      wait_cnt <= '0;
    end else if (issue) begin
      valid    <= 1'b1;
      addr     <= req.addr;
      wdata    <= req.wdata;
      wstrb    <= req.wstrb;
      wait_cnt <= '0;
    end else if (xfer_ok_c || xfer_timeout_c) begin
      valid    <= 1'b0;
      wait_cnt <= '0;
    end else if (valid) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_dma_master.sv
// Word-by-word memory copy initiator on the picorv32 native bus: read src+4i, then write dst+4i.
module mem_dma_master
  import mem_dma_master_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] rd_buf;

  logic     issue_c, load_c, capture_c, advance_c;
  bus_req_t req_c;
  logic     xfer_ok_c, xfer_timeout_c;

  mem_dma_master_bus_port #(
    .TIMEOUT(TIMEOUT)
  ) u_port (
    .clk           (clk),
    .rst           (rst),
    .issue         (issue_c),
    .req           (req_c),
    .ready         (mem_ready),
    .valid         (mem_valid),
    .addr          (mem_addr),
    .wdata         (mem_wdata),
    .wstrb         (mem_wstrb),
    .xfer_ok_c     (xfer_ok_c),
    .xfer_timeout_c(xfer_timeout_c)
  );

  // State register; status flags are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= is_active(state_n);
      done  <= (state_n == ST_DONE);
      error <= (state_n == ST_ERR);
    end
  end

  // Next state plus request issue; each request is launched from the cycle before it is visible
  always_comb begin
    state_n   = state;
    issue_c   = 1'b0;
    req_c     = '0;
    load_c    = 1'b0;
    capture_c = 1'b0;
    advance_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load_c = 1'b1;
          if (len == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n     = ST_RD;
            issue_c     = 1'b1;
            req_c.addr  = word_align(src_addr);
            req_c.wstrb = WSTRB_READ;
          end
        end
      end
      ST_RD: begin
        if (xfer_ok_c) begin
          capture_c = 1'b1;
          state_n   = ST_RGAP;
        end else if (xfer_timeout_c) begin
          state_n = ST_ERR;
        end
      end
      ST_RGAP: begin
        state_n     = ST_WR;
        issue_c     = 1'b1;
        req_c.addr  = dst_ptr;
        req_c.wdata = rd_buf;
        req_c.wstrb = WSTRB_WORD;
      end
      ST_WR: begin
        if (xfer_ok_c) begin
          advance_c = 1'b1;
          state_n   = (remaining == LEN_W'(1)) ? ST_DONE : ST_WGAP;
        end else if (xfer_timeout_c) begin
          state_n = ST_ERR;
        end
      end
      ST_WGAP: begin
        state_n     = ST_RD;
        issue_c     = 1'b1;
        req_c.addr  = src_ptr;
        req_c.wstrb = WSTRB_READ;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Copy pointers, word count and the single-word buffer; pointers wrap modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      rd_buf    <= '0;
    end else begin
      if (load_c) begin
        src_ptr   <= word_align(src_addr);
        dst_ptr   <= word_align(dst_addr);
        remaining <= len;
      end
      if (capture_c) begin
        rd_buf <= mem_rdata;
      end
      if (advance_c) begin
        src_ptr   <= src_ptr + ADDR_W'(4);
        dst_ptr   <= dst_ptr + ADDR_W'(4);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

endmodule
